sram_seq: RTL
=============

Name: sram_seq

Overview:
- Memory-access sequencer between the CPU load/store unit (upstream) and the memory/IO bridge that multiplexes the SRAM and switch/hex I/O (downstream).
- Turns a single-cycle CPU request into properly timed active-low SRAM strobes (CE, UB, LB, OE, WE) with parameterised wait states.
- Captures read data and returns a one-cycle completion pulse.
- All strobe and bus outputs are registered, so the SRAM and the I/O register at 0xFFFF never see glitches.

Parameters:
- ADDR_W, 20, address width.
- DATA_W, 16, data width.
- RD_WAIT, 2, cycles OE is held low before read data is sampled (min 1).
- WR_SETUP, 1, cycles address/data/CE are valid before WE falls (0 allowed).
- WR_PULSE, 2, cycles WE is held low (min 1).
- WR_HOLD, 1, cycles address/data/CE are held after WE rises (0 allowed).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Req  in  1  CPU request; sampled only in IDLE
- RNW  in  1  1 = read, 0 = write
- Addr  in  ADDR_W  request address
- WData  in  DATA_W  write data
- ByteEn  in  2  [1] = upper byte, [0] = lower byte
- Ack  out  1  one-cycle completion pulse
- Busy  out  1  high from acceptance through the Ack cycle
- RData  out  DATA_W  last read result; held until the next read completes
- Mem_Addr  out  ADDR_W  address to the bridge
- CE, UB, LB, OE, WE  out  1 each  active-low strobes to the bridge
- Data_Mem_In  in  DATA_W  read data from the bridge
- Data_Mem_Out  out  DATA_W  write data to the bridge

Behaviour:
- Reset: async and immediate. CE=UB=LB=OE=WE=1, Ack=0, Busy=0, RData=0, Mem_Addr=0, Data_Mem_Out=0, state=IDLE.
- Reset mid-transaction: strobes deassert immediately; the transaction is dropped with no Ack.
- States: IDLE, RD, WR_SU, WR_PW, WR_HD, DONE.
- IDLE, Req=1 at a clock edge: latch Addr, WData, RNW, ByteEn. Busy=1 from the next cycle.
  - ByteEn=00: go directly to DONE. No strobes; RData unchanged.
  - RNW=1: go to RD.
  - RNW=0: go to WR_SU, or to WR_PW if WR_SETUP=0.
- RD:
  - CE=0, OE=0, WE=1; UB=~ByteEn[1], LB=~ByteEn[0]; Mem_Addr=latched address.
  - Lasts exactly RD_WAIT cycles.
  - Data_Mem_In is registered into RData at the edge ending the last RD cycle; disabled byte lanes of RData are cleared to 0. Then go to DONE.
- WR_SU: CE=0, OE=1, WE=1, UB/LB as above, Data_Mem_Out=latched data. Lasts WR_SETUP cycles.
- WR_PW: as WR_SU but WE=0. Lasts WR_PULSE cycles. Go to WR_HD, or to DONE if WR_HOLD=0.
- WR_HD: as WR_SU. Lasts WR_HOLD cycles.
- Address and data are stable for the whole write; WE never falls in the same cycle CE first falls when WR_SETUP>=1.
- DONE (one cycle): all strobes = 1; Ack=1, Busy=1; RData is valid this cycle for reads. Next state is IDLE.
- Latency from the acceptance edge to Ack:
  - read: RD_WAIT+1 cycles
  - write: WR_SETUP+WR_PULSE+WR_HOLD+1 cycles
  - ByteEn=00: 1 cycle
- Back-to-back: Req is sampled in IDLE on the cycle after Ack. Minimum spacing between accepted requests is latency+1 cycles.
- Req asserted while Busy is ignored; request inputs are not re-sampled mid-transaction.
- Data_Mem_Out=0 whenever the state is not a WR_* state.
- Mem_Addr holds its last value in IDLE and DONE.
- Stage counter: loaded on each state entry with duration−1. The state advances when the counter is 0. No wrap-around is possible.

Decomposition:
- Package sram_seq_pkg:
  - state enum seq_state_t
  - default timing constants
  - typedef for byte-enable encoding
- Sub-module wait_counter: loadable down-counter with a zero flag, width $clog2(max stage length + 1). Instantiated once.

Test Plan:
- Read, defaults, Addr=0x00123, ByteEn=11, Data_Mem_In=0xBEEF: OE=0 and CE=0 for 2 cycles; Ack in cycle 3 after acceptance; RData=0xBEEF.
- Write, defaults, Addr=0x0FFFF, WData=0x1234, ByteEn=11: CE low 4 cycles; WE low only cycles 2–3; Data_Mem_Out=0x1234 throughout; Ack in cycle 5.
- Byte read, ByteEn=10, Data_Mem_In=0xA55A: UB=0, LB=1; RData=0xA500.
- ByteEn=00 with Req: no strobe toggles; Ack the next cycle; RData unchanged.
- Req held high for 20 cycles, reads: accepted every RD_WAIT+2=4 cycles; exactly one Ack per transaction; Req is ignored while Busy.
- Reset asserted during WR_PW: WE, CE and all strobes = 1 asynchronously; no Ack; after release the next read completes normally.

Source files
------------

// File: rtl/sram_seq_pkg.sv
// Shared types and default timing for the SRAM access sequencer.
package sram_seq_pkg;

   // Sequencer states; RD and WR_* are the only states that drive strobes low.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_WR_SU = 3'd2,
      S_WR_PW = 3'd3,
      S_WR_HD = 3'd4,
      S_DONE  = 3'd5
   } seq_state_t;

   // Byte-enable encoding: bit 1 selects the upper byte, bit 0 the lower byte.
   typedef logic [1:0] byte_en_t;
   localparam byte_en_t BE_NONE = 2'b00;

   localparam int DEF_ADDR_W   = 20;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_RD_WAIT  = 2;
   localparam int DEF_WR_SETUP = 1;
   localparam int DEF_WR_PULSE = 2;
   localparam int DEF_WR_HOLD  = 1;

   // Longest stage length, used to size the wait counter.
   function automatic int max_stage(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Counter load value for a stage of the given duration (zero-length stages are skipped).
   function automatic int load_value(input int dur);
      return (dur > 32'sd0) ? (dur - 32'sd1) : 32'sd0;
   endfunction

endpackage

// File: rtl/sram_seq_wait_counter.sv
// Loadable down-counter with a zero flag; paces each timed sequencer stage.
module wait_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
   localparam logic [W-1:0] CNT_ONE  = W'(32'd1);

   logic [W-1:0] count_r;

   // Load on stage entry, otherwise count down and stick at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= CNT_ZERO;
      end else if (load) begin
         count_r <= load_val;
      end else if (count_r != CNT_ZERO) begin
         count_r <= count_r - CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/sram_seq.sv
// Memory-access sequencer: turns a one-cycle CPU request into timed,
// glitch-free active-low SRAM strobes and returns a one-cycle Ack.
module sram_seq
   import sram_seq_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int RD_WAIT  = DEF_RD_WAIT,
   parameter int WR_SETUP = DEF_WR_SETUP,
   parameter int WR_PULSE = DEF_WR_PULSE,
   parameter int WR_HOLD  = DEF_WR_HOLD
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic              RNW,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WData,
   input  logic [1:0]        ByteEn,
   output logic              Ack,
   output logic              Busy,
   output logic [DATA_W-1:0] RData,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic              CE,
   output logic              UB,
   output logic              LB,
   output logic              OE,
   output logic              WE,
   input  logic [DATA_W-1:0] Data_Mem_In,
   output logic [DATA_W-1:0] Data_Mem_Out
);

   localparam int MAX_STAGE = max_stage(RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD);
   localparam int CNT_W     = $clog2(MAX_STAGE + 1);
   localparam int HALF      = DATA_W / 2;

   localparam logic [CNT_W-1:0] RD_LD = CNT_W'(load_value(RD_WAIT));
   localparam logic [CNT_W-1:0] SU_LD = CNT_W'(load_value(WR_SETUP));
   localparam logic [CNT_W-1:0] PW_LD = CNT_W'(load_value(WR_PULSE));
   localparam logic [CNT_W-1:0] HD_LD = CNT_W'(load_value(WR_HOLD));

   localparam logic HAS_SETUP = (WR_SETUP > 32'sd0);
   localparam logic HAS_HOLD  = (WR_HOLD > 32'sd0);

   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

   // Expand the byte enables into a data-width lane mask.
   function automatic logic [DATA_W-1:0] lane_mask(input byte_en_t be);
      return {{(DATA_W - HALF){be[1]}}, {HALF{be[0]}}};
   endfunction

   seq_state_t        state_r;
   byte_en_t          be_r;
   logic              ack_r;
   logic              busy_r;
   logic [DATA_W-1:0] rdata_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] dout_r;
   logic              ce_r;
   logic              ub_r;
   logic              lb_r;
   logic              oe_r;
   logic              we_r;

   logic              cnt_load_s;
   logic [CNT_W-1:0]  cnt_val_s;
   logic              cnt_zero_s;

   wait_counter #(.W(CNT_W)) u_wait (
      .clk      (Clk),
      .rst      (Reset),
      .load     (cnt_load_s),
      .load_val (cnt_val_s),
      .zero     (cnt_zero_s)
   );

   // Reload the stage counter whenever a timed stage is entered.
   always_comb begin
      cnt_load_s = 1'b0;
      cnt_val_s  = RD_LD;
      case (state_r)
         S_IDLE: begin
            if (Req && (ByteEn != BE_NONE)) begin
               cnt_load_s = 1'b1;
               if (RNW) begin
                  cnt_val_s = RD_LD;
               end else if (HAS_SETUP) begin
                  cnt_val_s = SU_LD;
               end else begin
                  cnt_val_s = PW_LD;
               end
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         S_WR_SU: begin
            if (cnt_zero_s) begin
               cnt_load_s = 1'b1;
               cnt_val_s  = PW_LD;
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         S_WR_PW: begin
            if (cnt_zero_s && HAS_HOLD) begin
               cnt_load_s = 1'b1;
               cnt_val_s  = HD_LD;
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         default: begin
            cnt_load_s = 1'b0;
         end
      endcase
   end

   // Sequencer FSM; every strobe and bus output is a register updated with the state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= S_IDLE;
         be_r       <= BE_NONE;
         ack_r      <= 1'b0;
         busy_r     <= 1'b0;
         rdata_r    <= DATA_ZERO;
         mem_addr_r <= ADDR_ZERO;
         dout_r     <= DATA_ZERO;
         ce_r       <= 1'b1;
         ub_r       <= 1'b1;
         lb_r       <= 1'b1;
         oe_r       <= 1'b1;
         we_r       <= 1'b1;
      end else begin
         case (state_r)
            S_IDLE: begin
               ack_r <= 1'b0;
               if (Req) begin
                  be_r   <= ByteEn;
                  busy_r <= 1'b1;
                  if (ByteEn == BE_NONE) begin
                     // Nothing to access: complete without touching the bus.
                     state_r <= S_DONE;
                     ack_r   <= 1'b1;
                  end else begin
                     mem_addr_r <= Addr;
                     ce_r       <= 1'b0;
                     ub_r       <= ~ByteEn[1];
                     lb_r       <= ~ByteEn[0];
                     if (RNW) begin
                        state_r <= S_RD;
                        oe_r    <= 1'b0;
                     end else begin
                        dout_r <= WData;
                        if (HAS_SETUP) begin
                           state_r <= S_WR_SU;
                        end else begin
                           state_r <= S_WR_PW;
                           we_r    <= 1'b0;
                        end
                     end
                  end
               end
            end
            S_RD: begin
               if (cnt_zero_s) begin
                  rdata_r <= Data_Mem_In & lane_mask(be_r);
                  state_r <= S_DONE;
                  ack_r   <= 1'b1;
                  ce_r    <= 1'b1;
                  ub_r    <= 1'b1;
                  lb_r    <= 1'b1;
                  oe_r    <= 1'b1;
               end
            end
            S_WR_SU: begin
               if (cnt_zero_s) begin
                  state_r <= S_WR_PW;
                  we_r    <= 1'b0;
               end
            end
            S_WR_PW: begin
               if (cnt_zero_s) begin
                  we_r <= 1'b1;
                  if (HAS_HOLD) begin
                     state_r <= S_WR_HD;
                  end else begin
                     state_r <= S_DONE;
                     ack_r   <= 1'b1;
                     ce_r    <= 1'b1;
                     ub_r    <= 1'b1;
                     lb_r    <= 1'b1;
                     dout_r  <= DATA_ZERO;
                  end
               end
            end
            S_WR_HD: begin
               if (cnt_zero_s) begin
                  state_r <= S_DONE;
                  ack_r   <= 1'b1;
                  ce_r    <= 1'b1;
                  ub_r    <= 1'b1;
                  lb_r    <= 1'b1;
                  dout_r  <= DATA_ZERO;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
               ack_r   <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= S_IDLE;
               ack_r   <= 1'b0;
               busy_r  <= 1'b0;
               dout_r  <= DATA_ZERO;
               ce_r    <= 1'b1;
               ub_r    <= 1'b1;
               lb_r    <= 1'b1;
               oe_r    <= 1'b1;
               we_r    <= 1'b1;
            end
         endcase
      end
   end

   assign Ack          = ack_r;
   assign Busy         = busy_r;
   assign RData        = rdata_r;
   assign Mem_Addr     = mem_addr_r;
   assign Data_Mem_Out = dout_r;
   assign CE           = ce_r;
   assign UB           = ub_r;
   assign LB           = lb_r;
   assign OE           = oe_r;
   assign WE           = we_r;

endmodule
